// File: rtl/flyback_ctrl_pkg.sv
// Shared definitions for the flyback controller register block:
// register map, CTRL/STATUS bit positions, AXI response codes and FSM states.
package flyback_ctrl_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_UPD_BIT    = 1;
    localparam int STATUS_PEND_BIT = 0;
    localparam int STATUS_EN_BIT   = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // On-time can never exceed the period it is loaded with.
    function automatic logic [15:0] clamp_duty(input logic [15:0] duty,
                                               input logic [15:0] period);
        return (duty > period) ? period : duty;
    endfunction

endpackage

// File: rtl/flyback_shadow_update.sv
// Shadow-register loader: holds a pending update until the PWM stage is at a
// period boundary (or idle), then copies PERIOD and clamped DUTY atomically.
module flyback_shadow_update
    import flyback_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd_req,
    input  logic        pwm_en,
    input  logic        pwm_cycle_end,
    input  logic [15:0] period,
    input  logic [15:0] duty,
    output logic [15:0] shadow_period,
    output logic [15:0] shadow_duty,
    output logic        upd_done,
    output logic        update_pending
);

    logic load_now;

    assign load_now = update_pending && (pwm_cycle_end || !pwm_en);

    // A request arriving on the load cycle re-arms pending for a later load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_period  <= '0;
            shadow_duty    <= '0;
            upd_done       <= 1'b0;
            update_pending <= 1'b0;
        end else begin
            upd_done <= load_now;
            if (upd_req) begin
                update_pending <= 1'b1;
            end else if (load_now) begin
                update_pending <= 1'b0;
            end
            if (load_now) begin
                shadow_period <= period;
                shadow_duty   <= clamp_duty(duty, period);
            end
        end
    end

endmodule

// File: rtl/flyback_ctrl_axil_regs.sv
// AXI4-Lite slave exposing CTRL/PERIOD/DUTY/STATUS for the flyback PWM stage,
// with double-buffered (shadowed) period and duty outputs.
module flyback_ctrl_axil_regs
    import flyback_ctrl_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            pwm_en_o,
    output logic [15:0]                     pwm_period_o,
    output logic [15:0]                     pwm_duty_o,
    input  logic                            pwm_cycle_end_i,
    output logic                            upd_done_o
);

    wr_state_t w_state, w_next;
    rd_state_t r_state, r_next;

    logic        w_hs;
    logic        ar_hs;
    logic [1:0]  w_addr;
    logic [1:0]  r_addr;
    logic        ctrl_en;
    logic [15:0] period_reg;
    logic [15:0] duty_reg;
    logic        upd_req;
    logic        update_pending;
    logic [C_S_AXI_DATA_WIDTH-1:0] read_mux;
    logic        unused_bits;

    assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0],
                           s00_axi_araddr[1:0], s00_axi_wdata[31:16], s00_axi_wstrb[3:2]};

    assign w_addr = s00_axi_awaddr[3:2];
    assign r_addr = s00_axi_araddr[3:2];

    // Gating with reset keeps the ready strobes low while the block is held in reset.
    assign w_hs  = s00_axi_aresetn && (w_state == W_IDLE) && s00_axi_awvalid && s00_axi_wvalid;
    assign ar_hs = s00_axi_aresetn && (r_state == R_IDLE) && s00_axi_arvalid;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            w_state <= W_IDLE;
            r_state <= R_IDLE;
        end else begin
            w_state <= w_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (w_hs) w_next = W_RESP;
            W_RESP:  if (s00_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_awready = 1'b0;
        s00_axi_wready  = 1'b0;
        s00_axi_bvalid  = 1'b0;
        s00_axi_bresp   = RESP_OKAY;
        case (w_state)
            W_IDLE: begin
                s00_axi_awready = w_hs;
                s00_axi_wready  = w_hs;
            end
            W_RESP:  s00_axi_bvalid = 1'b1;
            default: s00_axi_bvalid = 1'b0;
        endcase
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (s00_axi_rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        s00_axi_arready = 1'b0;
        s00_axi_rvalid  = 1'b0;
        s00_axi_rresp   = RESP_OKAY;
        case (r_state)
            R_IDLE:  s00_axi_arready = ar_hs;
            R_DATA:  s00_axi_rvalid  = 1'b1;
            default: s00_axi_rvalid  = 1'b0;
        endcase
    end

    // Byte strobes only matter for the low two bytes; upper bytes are not stored.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            ctrl_en    <= 1'b0;
            period_reg <= '0;
            duty_reg   <= '0;
        end else if (w_hs) begin
            case (w_addr)
                REG_CTRL: begin
                    if (s00_axi_wstrb[0]) ctrl_en <= s00_axi_wdata[CTRL_EN_BIT];
                end
                REG_PERIOD: begin
                    if (s00_axi_wstrb[0]) period_reg[7:0]  <= s00_axi_wdata[7:0];
                    if (s00_axi_wstrb[1]) period_reg[15:8] <= s00_axi_wdata[15:8];
                end
                REG_DUTY: begin
                    if (s00_axi_wstrb[0]) duty_reg[7:0]  <= s00_axi_wdata[7:0];
                    if (s00_axi_wstrb[1]) duty_reg[15:8] <= s00_axi_wdata[15:8];
                end
                default: ;
            endcase
        end
    end

    assign upd_req = w_hs && (w_addr == REG_CTRL) && s00_axi_wstrb[0]
                     && s00_axi_wdata[CTRL_UPD_BIT];

    always_comb begin
        read_mux = '0;
        case (r_addr)
            REG_CTRL:   read_mux[CTRL_EN_BIT] = ctrl_en;
            REG_PERIOD: read_mux[15:0] = period_reg;
            REG_DUTY:   read_mux[15:0] = duty_reg;
            REG_STATUS: begin
                read_mux[STATUS_PEND_BIT] = update_pending;
                read_mux[STATUS_EN_BIT]   = pwm_en_o;
            end
            default: read_mux = '0;
        endcase
    end

    // Captured on the accept edge, so a same-cycle write is not yet visible.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            s00_axi_rdata <= '0;
            pwm_en_o      <= 1'b0;
        end else begin
            if (ar_hs) s00_axi_rdata <= read_mux;
            pwm_en_o <= ctrl_en;
        end
    end

    flyback_shadow_update u_shadow (
        .clk            (s00_axi_aclk),
        .rst_n          (s00_axi_aresetn),
        .upd_req        (upd_req),
        .pwm_en         (pwm_en_o),
        .pwm_cycle_end  (pwm_cycle_end_i),
        .period         (period_reg),
        .duty           (duty_reg),
        .shadow_period  (pwm_period_o),
        .shadow_duty    (pwm_duty_o),
        .upd_done       (upd_done_o),
        .update_pending (update_pending)
    );

endmodule
